// File: rtl/sync_fifo_flags_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_flags_pkg
// Purpose  : Shared definitions for the single-clock FIFO: default data and
//            address widths, the DEPTH = 1 << ASIZE helper and the threshold
//            legality checks applied at elaboration time.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package sync_fifo_flags_pkg;

    localparam int c_DEF_DSIZE = 8;
    localparam int c_DEF_ASIZE = 4;

    // Number of storage entries for a given address width.
    function automatic int fifo_depth(input int asize);
        return 1 << asize;
    endfunction

    // Almost-full threshold must lie in 1..DEPTH so the flag can both
    // assert and deassert.
    function automatic bit afull_th_ok(input int th, input int asize);
        return (th >= 1) && (th <= fifo_depth(asize));
    endfunction

    // Almost-empty threshold must lie in 0..DEPTH-1 for the same reason.
    function automatic bit aempty_th_ok(input int th, input int asize);
        return (th >= 0) && (th < fifo_depth(asize));
    endfunction

endpackage : sync_fifo_flags_pkg
`default_nettype wire

// File: rtl/sync_fifo_flags_if.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_flags_if
// Purpose  : Write/read handshake and status bundle of the single-clock FIFO.
// Ports    : master - producer/consumer side (drives wdata, winc, rinc)
//            slave  - FIFO side (drives rdata, flags, error pulses, count)
// Revision : 1.0  initial release
// ============================================================================
interface sync_fifo_flags_if
    import sync_fifo_flags_pkg::*;
#(
    parameter int DSIZE = c_DEF_DSIZE,
    parameter int ASIZE = c_DEF_ASIZE
);

    logic [DSIZE-1:0] wdata;
    logic             winc;
    logic             wfull;
    logic             walmost_full;
    logic             overflow;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             ralmost_empty;
    logic             underflow;
    logic [ASIZE:0]   count;

    modport master (
        output wdata, winc, rinc,
        input  wfull, walmost_full, overflow,
        input  rdata, rempty, ralmost_empty, underflow, count
    );

    modport slave (
        input  wdata, winc, rinc,
        output wfull, walmost_full, overflow,
        output rdata, rempty, ralmost_empty, underflow, count
    );

endinterface : sync_fifo_flags_if
`default_nettype wire

// File: rtl/sync_fifo_flags_mem.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_flags_mem
// Purpose  : DEPTH x DSIZE register array for the single-clock FIFO.
//            Synchronous write port, plus two read ports on the same address:
//            a registered one (cleared by reset) and a combinational one.
//            The parent picks which read port it uses.
// Ports    : clk        - clock, rising edge
//            rst_n      - synchronous active-low reset (read register only)
//            wclken     - write enable
//            waddr      - write address
//            wdata      - write data
//            rclken     - registered-read enable
//            raddr      - read address (shared by both read ports)
//            rdata_reg  - registered read data, holds when rclken is low
//            rdata_comb - combinational read data
// Revision : 1.0  initial release
// ============================================================================
module sync_fifo_flags_mem
    import sync_fifo_flags_pkg::*;
#(
    parameter int DSIZE = c_DEF_DSIZE,
    parameter int ASIZE = c_DEF_ASIZE
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             wclken,
    input  wire logic [ASIZE-1:0] waddr,
    input  wire logic [DSIZE-1:0] wdata,
    input  wire logic             rclken,
    input  wire logic [ASIZE-1:0] raddr,
    output logic      [DSIZE-1:0] rdata_reg,
    output logic      [DSIZE-1:0] rdata_comb
);

    localparam int c_DEPTH = fifo_depth(ASIZE);

    // Storage is deliberately not reset.
    logic [DSIZE-1:0] r_mem [c_DEPTH];
    logic [DSIZE-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (wclken) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (rclken) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata_reg  = r_rdata;
    assign rdata_comb = r_mem[raddr];

endmodule : sync_fifo_flags_mem
`default_nettype wire

// File: rtl/sync_fifo_flags.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_flags
// Purpose  : Single-clock FIFO with occupancy count, programmable
//            almost-full / almost-empty flags, optional first-word-fall-
//            through read, and one-cycle overflow / underflow pulses.
// Ports    : clk   - clock, rising edge
//            rst_n - synchronous active-low reset
//            bus   - slave side of sync_fifo_flags_if:
//                    wdata/winc in, wfull/walmost_full/overflow out,
//                    rinc in, rdata/rempty/ralmost_empty/underflow out,
//                    count out (0..DEPTH)
// Revision : 1.0  initial release
// ============================================================================
module sync_fifo_flags
    import sync_fifo_flags_pkg::*;
#(
    parameter int DSIZE     = c_DEF_DSIZE,
    parameter int ASIZE     = c_DEF_ASIZE,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    sync_fifo_flags_if.slave bus
);

    localparam int             c_DEPTH     = fifo_depth(ASIZE);
    localparam logic [ASIZE:0] c_DEPTH_CNT = (ASIZE+1)'(c_DEPTH);
    localparam logic [ASIZE:0] c_AFULL_TH  = (ASIZE+1)'(AFULL_TH);
    localparam logic [ASIZE:0] c_AEMPTY_TH = (ASIZE+1)'(AEMPTY_TH);

    // ------------------------------------------------------------------
    // Elaboration-time parameter legality
    // ------------------------------------------------------------------
    generate
        if (!afull_th_ok(AFULL_TH, ASIZE)) begin : g_bad_afull_th
            $error("sync_fifo_flags: AFULL_TH must be in 1..DEPTH");
        end
        if (!aempty_th_ok(AEMPTY_TH, ASIZE)) begin : g_bad_aempty_th
            $error("sync_fifo_flags: AEMPTY_TH must be in 0..DEPTH-1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ASIZE:0]   r_wptr;
    logic [ASIZE:0]   r_rptr;
    logic [ASIZE:0]   r_count;
    logic             r_wfull;
    logic             r_walmost_full;
    logic             r_overflow;
    logic             r_rempty;
    logic             r_ralmost_empty;
    logic             r_underflow;

    logic             w_we;
    logic             w_re;
    logic [ASIZE:0]   w_wptr_next;
    logic [ASIZE:0]   w_rptr_next;
    logic [ASIZE:0]   w_count_next;
    logic [DSIZE-1:0] w_rdata_reg;
    logic [DSIZE-1:0] w_rdata_comb;
    logic [DSIZE-1:0] w_rdata;

    // Acceptance looks only at registered flags: at full a write is refused
    // even if a read is taken in the same cycle, and at empty the reverse.
    assign w_we = bus.winc && !r_wfull;
    assign w_re = bus.rinc && !r_rempty;

    assign w_wptr_next = r_wptr + {{ASIZE{1'b0}}, w_we};
    assign w_rptr_next = r_rptr + {{ASIZE{1'b0}}, w_re};

    // Pointers carry one extra wrap bit, so their modular difference is the
    // exact occupancy 0..DEPTH (equivalent to count + we - re).
    assign w_count_next = w_wptr_next - w_rptr_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_count         <= '0;
            r_wfull         <= 1'b0;
            r_walmost_full  <= 1'b0;
            r_overflow      <= 1'b0;
            r_rempty        <= 1'b1;
            r_ralmost_empty <= 1'b1;
            r_underflow     <= 1'b0;
        end else begin
            r_wptr          <= w_wptr_next;
            r_rptr          <= w_rptr_next;
            r_count         <= w_count_next;
            r_wfull         <= (w_count_next == c_DEPTH_CNT);
            r_walmost_full  <= (w_count_next >= c_AFULL_TH);
            r_rempty        <= (w_count_next == '0);
            r_ralmost_empty <= (w_count_next <= c_AEMPTY_TH);
            r_overflow      <= bus.winc && r_wfull;
            r_underflow     <= bus.rinc && r_rempty;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    // Gating the write with rst_n keeps a winc in the reset cycle from
    // touching the array.
    sync_fifo_flags_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk        (clk),
        .rst_n      (rst_n),
        .wclken     (w_we && rst_n),
        .waddr      (r_wptr[ASIZE-1:0]),
        .wdata      (bus.wdata),
        .rclken     (w_re),
        .raddr      (r_rptr[ASIZE-1:0]),
        .rdata_reg  (w_rdata_reg),
        .rdata_comb (w_rdata_comb)
    );

    // In FWFT mode the head word is shown directly; while empty the output
    // is forced to zero so it never exposes stale or uninitialised storage.
    always_comb begin
        w_rdata = w_rdata_reg;
        if (FWFT != 0) begin
            w_rdata = r_rempty ? '0 : w_rdata_comb;
        end
    end

    assign bus.wfull         = r_wfull;
    assign bus.walmost_full  = r_walmost_full;
    assign bus.overflow      = r_overflow;
    assign bus.rdata         = w_rdata;
    assign bus.rempty        = r_rempty;
    assign bus.ralmost_empty = r_ralmost_empty;
    assign bus.underflow     = r_underflow;
    assign bus.count         = r_count;

endmodule : sync_fifo_flags
`default_nettype wire
